// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state encodings, stage indices and hold/NOP mask helpers for pipe_ctrl
package pipe_ctrl_pkg;
  typedef enum logic [2:0] {
    ST_RUN      = 3'd0,
    ST_MEM_WAIT = 3'd1,
    ST_HALT     = 3'd2,
    ST_STEP     = 3'd3,
    ST_ERR      = 3'd4
  } state_t;
  localparam int STG_PC    = 0;
  localparam int STG_IFID  = 1;
  localparam int STG_IDEX  = 2;
  localparam int STG_EXMEM = 3;
  localparam int STG_MEMWB = 4;
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;
  function automatic logic [4:0] hold_thru(input int stg);
    return 5'((1 << (stg + 1)) - 1);
  endfunction
  function automatic logic [3:0] nop_into(input int stg);
    return 4'(1 << (stg - 1));
  endfunction
endpackage

// File: rtl/pipe_ctrl_mem_wait_timer.sv
// mem_wait_timer: counts consecutive data-RAM wait cycles and flags the last allowed one
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic term
);
  localparam int W = $clog2(MEM_TIMEOUT);
  logic [W-1:0] cnt;
  // clear wins over enable
  always_ff @(posedge clk)
    cnt <= (rst || clr) ? '0 : en ? cnt + W'(1) : cnt;
  assign term = cnt == W'(MEM_TIMEOUT - 1);
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/bubble sequencer for the 5-stage pipeline with RAM-wait timeout and debug halt/step
import pipe_ctrl_pkg::*;
module pipe_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_use,
  input  logic             jump_reg,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             dbg_halt,
  input  logic             dbg_step,
  output logic [4:0]       stall,
  output logic [3:0]       bubble,
  output logic             halted,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);
  state_t state, state_nxt;
  logic step_pend, step_pend_nxt;
  logic tmr_clr, tmr_en, tmr_term, mem_hold;
  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (tmr_clr),
    .en   (tmr_en),
    .term (tmr_term)
  );
  // state, return-to-halt flag for a stepped RAM wait, saturating stall counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RUN;
      step_pend <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state     <= state_nxt;
      step_pend <= step_pend_nxt;
      if (stall[STG_PC] && state != ST_HALT && state != ST_ERR && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
  // hold/NOP outputs and next state from state and hazard inputs
  always_comb begin
    mem_hold      = (state == ST_MEM_WAIT) ? !mem_ready : (mem_req && !mem_ready);
    stall         = '0;
    bubble        = '0;
    state_nxt     = state;
    step_pend_nxt = step_pend;
    tmr_clr       = 1'b1;
    tmr_en        = 1'b0;
    if (state == ST_HALT || state == ST_ERR)
      stall = hold_thru(STG_MEMWB);
    else if (mem_hold) begin
      stall  = hold_thru(STG_EXMEM);
      bubble = nop_into(STG_MEMWB);
    end else if (load_use) begin
      stall  = hold_thru(STG_IFID);
      bubble = nop_into(STG_IDEX);
    end else if (jump_reg)
      bubble = nop_into(STG_IFID);
    case (state)
      ST_RUN, ST_STEP:
        if (mem_hold) begin
          state_nxt     = ST_MEM_WAIT;
          step_pend_nxt = state == ST_STEP;
          tmr_clr       = 1'b0;
          tmr_en        = 1'b1;
        end else if (state == ST_STEP || dbg_halt)
          state_nxt = ST_HALT;
      ST_MEM_WAIT:
        if (mem_ready) begin
          state_nxt     = step_pend ? ST_HALT : ST_RUN;
          step_pend_nxt = 1'b0;
        end else if (tmr_term)
          state_nxt = ST_ERR;
        else begin
          tmr_clr = 1'b0;
          tmr_en  = 1'b1;
        end
      ST_HALT: state_nxt = dbg_step ? ST_STEP : dbg_halt ? ST_HALT : ST_RUN;
      default: state_nxt = ST_ERR;
    endcase
    if (rst) begin
      stall  = '0;
      bubble = '0;
    end
  end
  assign halted  = !rst && state == ST_HALT;
  assign mem_err = !rst && state == ST_ERR;
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: scoreboard bench for pipe_ctrl against a behavioural pipeline-mode model
module tb_pipe_ctrl;
  localparam int TO = 4;
  localparam int CW = 6;
  logic clk = 1'b0, rst = 1'b1;
  logic load_use = 1'b0, jump_reg = 1'b0, mem_req = 1'b0, mem_ready = 1'b0;
  logic dbg_halt = 1'b0, dbg_step = 1'b0;
  logic [4:0] stall;
  logic [3:0] bubble;
  logic halted, mem_err;
  logic [CW-1:0] stall_cnt;
  typedef struct packed {
    logic [4:0]    stall;
    logic [3:0]    bubble;
    logic          halted;
    logic          mem_err;
    logic [CW-1:0] cnt;
  } exp_t;
  exp_t sb[$];
  int errors = 0, checks = 0;
  bit m_err = 0, m_halt = 0, m_step = 0, m_wait = 0, m_step_wait = 0;
  int m_waits = 0, m_cnt = 0;
  bit dh_lvl = 0;

  pipe_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .load_use  (load_use),
    .jump_reg  (jump_reg),
    .mem_req   (mem_req),
    .mem_ready (mem_ready),
    .dbg_halt  (dbg_halt),
    .dbg_step  (dbg_step),
    .stall     (stall),
    .bubble    (bubble),
    .halted    (halted),
    .mem_err   (mem_err),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input bit r, input bit lu, input bit jr, input bit mq, input bit mr,
                     input bit dh, input bit ds);
    int depth, bstage;
    bit busy, frozen;
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; load_use = lu; jump_reg = jr; mem_req = mq; mem_ready = mr;
    dbg_halt = dh; dbg_step = ds;
    depth = 0;
    bstage = 0;
    frozen = m_err || m_halt;
    busy = m_wait ? !mr : (mq && !mr);
    if (!r) begin
      if (frozen) depth = 5;
      else if (busy) begin depth = 4; bstage = 4; end
      else if (lu) begin depth = 2; bstage = 2; end
      else if (jr) bstage = 1;
    end
    e.stall   = 5'((1 << depth) - 1);
    e.bubble  = (bstage == 0) ? 4'd0 : 4'(1 << (bstage - 1));
    e.halted  = !r && m_halt;
    e.mem_err = !r && m_err;
    e.cnt     = CW'(m_cnt);
    sb.push_back(e);
    if (r) begin
      m_err = 0; m_halt = 0; m_step = 0; m_wait = 0; m_step_wait = 0; m_waits = 0; m_cnt = 0;
    end else begin
      if (depth > 0 && !frozen && m_cnt < (1 << CW) - 1) m_cnt++;
      if (m_err) begin
      end else if (m_halt) begin
        if (ds) begin m_halt = 0; m_step = 1; end
        else if (!dh) m_halt = 0;
      end else if (m_wait) begin
        if (mr) begin m_wait = 0; m_halt = m_step_wait; m_step_wait = 0; end
        else begin
          m_waits++;
          if (m_waits >= TO) begin m_err = 1; m_wait = 0; end
        end
      end else if (busy) begin
        m_wait = 1; m_waits = 1; m_step_wait = m_step; m_step = 0;
      end else if (m_step) begin
        m_step = 0; m_halt = 1;
      end else if (dh) m_halt = 1;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic [5:0] s1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("stall", int'(stall), int'(e.stall));
      chk("bubble", int'(bubble), int'(e.bubble));
      chk("halted", int'(halted), int'(e.halted));
      chk("mem_err", int'(mem_err), int'(e.mem_err));
      chk("stall_cnt", int'(stall_cnt), int'(e.cnt));
      s1 = {1'b0, stall} + 6'd1;
      chk("stall_prefix", int'(s1[4:0] & stall), 0);
      chk("hold_nop_overlap", int'(stall[4:1] & bubble), 0);
    end
  end

  initial begin
    @(posedge clk);
    cyc(1,0,0,0,0,0,0); cyc(1,0,0,0,0,0,0);
    cyc(0,1,0,0,0,0,0); cyc(0,0,0,0,0,0,0);
    cyc(0,0,0,1,0,0,0); cyc(0,0,0,1,0,0,0); cyc(0,0,0,1,0,0,0);
    cyc(0,0,0,1,1,0,0); cyc(0,0,0,0,0,0,0);
    cyc(0,0,0,1,0,0,0); cyc(0,0,0,1,0,0,0);
    cyc(1,0,0,1,0,0,0); cyc(1,0,0,0,0,0,0); cyc(0,0,0,0,0,0,0);
    cyc(0,0,0,1,0,0,0); cyc(0,0,1,1,0,0,0); cyc(0,1,1,1,0,0,0);
    cyc(0,0,1,1,1,0,0); cyc(0,0,0,0,0,0,0);
    for (int i = 0; i < 7; i++) cyc(0,0,0,1,0,0,0);
    cyc(0,0,0,0,1,0,0); cyc(1,0,0,0,0,0,0);
    cyc(0,0,0,0,0,1,0); cyc(0,0,0,0,0,1,0);
    cyc(0,0,0,0,0,1,1); cyc(0,0,0,0,0,1,0); cyc(0,0,0,0,0,1,1);
    cyc(0,0,0,0,0,1,0); cyc(0,0,0,0,0,1,0);
    cyc(0,0,0,0,0,1,1); cyc(0,0,0,1,0,1,0); cyc(0,0,0,1,0,1,0);
    cyc(0,0,0,1,1,1,0); cyc(0,0,0,0,0,1,0);
    cyc(0,0,0,0,0,0,0); cyc(0,0,0,0,0,0,0);
    for (int i = 0; i < 70; i++) cyc(0,1,0,0,0,0,0);
    cyc(1,0,0,0,0,0,0);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) dh_lvl = ~dh_lvl;
      cyc($urandom_range(0, 59) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, dh_lvl,
          $urandom_range(0, 5) == 0);
    end
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
